ad9363_tx_sample_pacer: RTL and testbench
=========================================

# ad9363_tx_sample_pacer

Buffers user-logic IQ samples in a small synchronous FIFO and releases them to the AD9363 LVDS transmit interface. It emits `dac_valid` at the exact cadence that interface expects: one pulse every 2 `fb_clk` cycles in 1R1T mode, every 4 in 2R2T mode. It sits directly upstream of the LVDS TX serializer, in the `fb_clk` domain. On FIFO underflow it keeps framing continuous by substituting zero samples.

## Interface
Parameters:
- `FIFO_DEPTH`, 16, number of sample words; power of 2, minimum 4.
- `PRIME_LEVEL`, 4, FIFO occupancy required before streaming starts; range 1..FIFO_DEPTH.

Ports:
- `fb_clk` in 1: sole clock.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `mode_1r1t` in 1: 1 = 1R1T (2-cycle period), 0 = 2R2T (4-cycle period). Latched on the IDLE->PRIME transition.
- `tx_enable` in 1: request to stream.
- `s_valid` in 1: user sample word valid.
- `s_ready` out 1: equals `!full`; 0 during reset.
- `s_data_i0`, `s_data_q0`, `s_data_i1`, `s_data_q1` in 12 each: user samples, two's complement.
- `dac_valid` out 1: one-cycle strobe to the serializer.
- `dac_data_i0`, `dac_data_q0`, `dac_data_i1`, `dac_data_q1` out 12 each: registered, held between strobes.
- `fifo_level` out log2(FIFO_DEPTH)+1: current occupancy.
- `underflow_cnt` out 16: saturating count of zero-substituted strobes.
- `streaming` out 1: high in RUN.

## Operation
- Write: a 48-bit word {i0,q0,i1,q1} is stored when `s_valid && s_ready`. The FIFO holds exactly FIFO_DEPTH words; `s_ready` drops at full.
- State machine:
  - IDLE: `dac_valid` = 0. Goes to PRIME when `tx_enable` = 1, latching `mode_1r1t` into `mode_q`.
  - PRIME: waits for `fifo_level >= PRIME_LEVEL`, then goes to RUN with phase = 0. Returns to IDLE if `tx_enable` drops.
  - RUN: a phase counter counts 0..P-1 and wraps, with P = 2 if `mode_q` else 4.
    - At phase 0 with the FIFO non-empty: pop one word.
    - At phase 0 with the FIFO empty: produce all-zero data and increment `underflow_cnt`, saturating at 0xFFFF.
    - Either way, `dac_valid` pulses on the following cycle.
    - If `tx_enable` = 0 when phase = 0, go to IDLE instead, with no pop and no strobe.
- Changes on `mode_1r1t` outside IDLE are ignored until the next IDLE->PRIME transition.
- In 1R1T, i1/q1 are still popped and driven; the downstream stage ignores them.
- FIFO contents are retained across RUN->IDLE; there is no implicit flush.
- Push and pop in the same cycle leave `fifo_level` unchanged. Push to a full FIFO cannot occur because of `s_ready`.
- Reset: FIFO emptied, state IDLE, phase 0. All `dac_*` outputs, `underflow_cnt` and `streaming` are 0; `fifo_level` is 0.
- Reset asserted mid-RUN aborts immediately; no further strobes are issued.

## Timing
- `s_ready` is combinational from the full flag; `fifo_level` updates the cycle after a push or pop.
- PRIME sees the threshold met in cycle t. RUN with phase 0 starts at t+1. The pop occurs at t+1, and `dac_valid` plus the new data appear at t+2.
- In RUN, `dac_valid` is high exactly 1 cycle in every P, with no gaps, including across underflow.
- Data changes only in the cycle `dac_valid` rises and is stable for the remaining P-1 cycles.
- The final strobe before IDLE belongs to the last completed period; `streaming` falls the cycle after leaving RUN.

## Structure
- Package `ad9363_tx_pkg` contains:
  - `SAMPLE_W` = 12.
  - The state enum {IDLE, PRIME, RUN}.
  - The period constants P_1R1T = 2 and P_2R2T = 4.
  - The 48-bit sample-word typedef.
- Sub-module `ad9363_tx_fifo`: synchronous single-clock FIFO with binary pointers plus an extra wrap bit, a count output, and registered read data.
- The state machine, phase counter and underflow counter live in the top module.

## Test plan
- Reset then 2R2T: push 8 words with i0 = 1..8, assert `tx_enable`.
  - Expect `dac_valid` every 4 cycles, `dac_data_i0` = 1,2,…,8 in order, and first strobe 2 cycles after level reaches 4.
- 1R1T: push 6 words, enable.
  - Expect strobes every 2 cycles carrying the 6 words, then zero data with `underflow_cnt` = 1,2,3… while strobes continue.
- Fill to 16 with `tx_enable` = 0.
  - Expect `s_ready` = 0 and a 17th push dropped.
  - Then enable: expect exactly 16 non-zero strobes.
- Deassert `tx_enable` at phase 2 in 2R2T.
  - Expect no strobe after the current period and IDLE at the next phase-0 boundary.
  - Remaining FIFO words must be preserved and emitted first on re-enable.
- Toggle `mode_1r1t` during RUN.
  - Expect the period unchanged until IDLE->PRIME, then the new period.
- Assert `rst_n` = 0 mid-RUN with 5 words queued.
  - Expect next-cycle outputs all 0 and `fifo_level` = 0; after release, no strobes until the FIFO is primed again.

Source files
------------

// File: rtl/ad9363_tx_pkg.sv
// Shared types and constants for the AD9363 transmit sample pacer.
// Sample word layout is {i0, q0, i1, q1}, MSB first.
package ad9363_tx_pkg;

  localparam int SAMPLE_W = 12;
  localparam int P_1R1T   = 2;
  localparam int P_2R2T   = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i0;
    logic [SAMPLE_W-1:0] q0;
    logic [SAMPLE_W-1:0] i1;
    logic [SAMPLE_W-1:0] q1;
  } sample_word_t;

endpackage

// File: rtl/ad9363_tx_fifo.sv
// Single-clock sample FIFO: binary pointers with an extra wrap bit,
// occupancy count and a read-data register that updates only on pop.
module ad9363_tx_fifo
  import ad9363_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  sample_word_t wr_data,
  input  logic         rd_en,
  output sample_word_t rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  sample_word_t mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_wr;
  logic         do_rd;

  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ad9363_tx_sample_pacer.sv
// Paces buffered IQ words onto the AD9363 TX serializer: one dac_valid strobe
// every 2 (1R1T) or 4 (2R2T) fb_clk cycles, zero-filling on underflow.
module ad9363_tx_sample_pacer
  import ad9363_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                fb_clk,
  input  logic                rst_n,
  input  logic                mode_1r1t,
  input  logic                tx_enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data_i0,
  input  logic [SAMPLE_W-1:0] s_data_q0,
  input  logic [SAMPLE_W-1:0] s_data_i1,
  input  logic [SAMPLE_W-1:0] s_data_q1,
  output logic                dac_valid,
  output logic [SAMPLE_W-1:0] dac_data_i0,
  output logic [SAMPLE_W-1:0] dac_data_q0,
  output logic [SAMPLE_W-1:0] dac_data_i1,
  output logic [SAMPLE_W-1:0] dac_data_q1,
  output logic [LW-1:0]       fifo_level,
  output logic [15:0]         underflow_cnt,
  output logic                streaming
);

  state_t       state, state_nxt;
  logic         mode_q, mode_nxt;
  logic [1:0]   phase, phase_nxt;
  logic [1:0]   phase_last;
  logic         strobe;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic         zero_q;
  logic         primed;
  sample_word_t wr_word;
  sample_word_t rd_word;

  assign s_ready = rst_n && !full;
  assign push    = s_valid && s_ready;
  assign wr_word = {s_data_i0, s_data_q0, s_data_i1, s_data_q1};
  assign pop     = strobe && !empty;

  ad9363_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (fb_clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .count   (fifo_level)
  );

  assign primed     = (fifo_level >= LW'(PRIME_LEVEL));
  assign phase_last = mode_q ? 2'(P_1R1T - 1) : 2'(P_2R2T - 1);

  // Period boundaries sit at phase 0: that is where we pop/strobe or stop.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    phase_nxt = phase;
    strobe    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable) begin
          state_nxt = PRIME;
          mode_nxt  = mode_1r1t;
        end
      end
      PRIME: begin
        if (!tx_enable) begin
          state_nxt = IDLE;
        end else if (primed) begin
          state_nxt = RUN;
          phase_nxt = 2'd0;
        end
      end
      RUN: begin
        if (phase == 2'd0 && !tx_enable) begin
          state_nxt = IDLE;
          phase_nxt = 2'd0;
        end else begin
          strobe    = (phase == 2'd0);
          phase_nxt = (phase == phase_last) ? 2'd0 : phase + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fb_clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      phase         <= 2'd0;
      dac_valid     <= 1'b0;
      zero_q        <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      phase     <= phase_nxt;
      dac_valid <= strobe;
      if (strobe) zero_q <= empty;
      if (strobe && empty && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  // FIFO read register holds the last popped word; zero_q masks it after underflow.
  assign dac_data_i0 = zero_q ? '0 : rd_word.i0;
  assign dac_data_q0 = zero_q ? '0 : rd_word.q0;
  assign dac_data_i1 = zero_q ? '0 : rd_word.i1;
  assign dac_data_q1 = zero_q ? '0 : rd_word.q1;
  assign streaming   = (state == RUN);

endmodule

// File: tb/tb_ad9363_tx_sample_pacer.sv
// Randomized and directed bench for ad9363_tx_sample_pacer, checked every
// cycle against a queue-based behavioural model plus literal expectations.
module tb_ad9363_tx_sample_pacer;

  localparam int DEPTH = 16;
  localparam int PLVL  = 4;
  localparam int LW    = 5;

  logic        fb_clk = 1'b0;
  logic        rst_n = 1'b0, mode_1r1t = 1'b0, tx_enable = 1'b0, s_valid = 1'b0;
  logic [11:0] s_i0 = '0, s_q0 = '0, s_i1 = '0, s_q1 = '0;
  logic        s_ready, dac_valid, streaming;
  logic [11:0] d_i0, d_q0, d_i1, d_q1;
  logic [LW-1:0] fifo_level;
  logic [15:0] underflow_cnt;

  ad9363_tx_sample_pacer #(.FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PLVL)) dut (
    .fb_clk(fb_clk), .rst_n(rst_n), .mode_1r1t(mode_1r1t), .tx_enable(tx_enable),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data_i0(s_i0), .s_data_q0(s_q0), .s_data_i1(s_i1), .s_data_q1(s_q1),
    .dac_valid(dac_valid), .dac_data_i0(d_i0), .dac_data_q0(d_q0),
    .dac_data_i1(d_i1), .dac_data_q1(d_q1), .fifo_level(fifo_level),
    .underflow_cnt(underflow_cnt), .streaming(streaming)
  );

  always #5 fb_clk = ~fb_clk;

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 0;
  int lvl4_cyc = -1;
  int log_i0[$], log_cyc[$], log_u[$];

  always @(posedge fb_clk) cyc <= cyc + 1;

  // Model: queue for the FIFO, a cycle count into RUN modulo the period.
  logic [47:0] mq[$];
  int          m_st = 0;            // 0 idle, 1 waiting for prime, 2 streaming
  int          m_per = 4, m_k = 0, m_ucnt = 0;
  bit          m_valid = 0;
  logic [47:0] m_data = '0;

  always @(posedge fb_clk) begin : model
    bit do_push, strobe;
    if (!rst_n) begin
      mq.delete(); m_st = 0; m_k = 0; m_ucnt = 0; m_valid = 0; m_data = '0;
    end else begin
      do_push = s_valid && (mq.size() < DEPTH);
      strobe = 0;
      if (m_st == 0) begin
        if (tx_enable) begin m_st = 1; m_per = mode_1r1t ? 2 : 4; end
      end else if (m_st == 1) begin
        if (!tx_enable) m_st = 0;
        else if (mq.size() >= PLVL) begin m_st = 2; m_k = 0; end
      end else begin
        if (m_k % m_per == 0) begin
          if (!tx_enable) m_st = 0; else strobe = 1;
        end
        m_k++;
      end
      if (strobe) begin
        if (mq.size() > 0) m_data = mq.pop_front();
        else begin m_data = '0; if (m_ucnt < 65535) m_ucnt++; end
      end
      m_valid = strobe;
      if (do_push) mq.push_back({s_i0, s_q0, s_i1, s_q1});
    end
  end

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge fb_clk) begin
    if (chk_en) begin
      check("dac_valid", dac_valid, m_valid);
      check("dac_data", {d_i0, d_q0, d_i1, d_q1}, m_data);
      check("fifo_level", fifo_level, mq.size());
      check("underflow_cnt", underflow_cnt, m_ucnt);
      check("streaming", streaming, m_st == 2);
      check("s_ready", s_ready, rst_n && (mq.size() < DEPTH));
    end
    if (lvl4_cyc < 0 && fifo_level >= 4) lvl4_cyc = cyc;
    if (dac_valid) begin
      log_i0.push_back(d_i0); log_cyc.push_back(cyc); log_u.push_back(underflow_cnt);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(negedge fb_clk); #1; end
  endtask

  task automatic clear_log();
    log_i0.delete(); log_cyc.delete(); log_u.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx_enable = 1'b0; s_valid = 1'b0; tick(1);
    rst_n = 1'b1; tick(1); clear_log();
  endtask

  task automatic push_words(int n, int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_i0 = 12'(base + i);
      s_q0 = 12'($urandom); s_i1 = 12'($urandom); s_q1 = 12'($urandom);
      tick(1);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_strobes(int n, int budget, string name);
    int t = 0;
    while (log_i0.size() < n && t < budget) begin tick(1); t++; end
    if (log_i0.size() < n) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d strobes expected %0d", name, log_i0.size(), n);
    end
  endtask

  task automatic check_spacing(int first, int last, int per, string name);
    for (int i = first + 1; i <= last && i < log_cyc.size(); i++)
      check(name, log_cyc[i] - log_cyc[i-1], per);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    tick(3);
    rst_n = 1'b1;
    chk_en = 1;
    tick(1);
    check("reset dac_valid", dac_valid, 0);
    check("reset level", fifo_level, 0);
    check("reset ucnt", underflow_cnt, 0);
    check("reset streaming", streaming, 0);
    check("reset data", {d_i0, d_q0, d_i1, d_q1}, 0);
    check("reset s_ready", s_ready, 1);

    // 2R2T, enable first then feed 8 words
    mode_1r1t = 0; tx_enable = 1; tick(2);
    lvl4_cyc = -1; clear_log();
    push_words(8, 1);
    wait_strobes(8, 100, "t1");
    for (int i = 0; i < 8 && i < log_i0.size(); i++) check("t1 order", log_i0[i], i + 1);
    check_spacing(0, 7, 4, "t1 spacing");
    if (log_cyc.size() > 0) check("t1 first strobe latency", log_cyc[0] - lvl4_cyc, 2);
    tx_enable = 0; tick(8);

    // 1R1T with underflow
    do_reset();
    mode_1r1t = 1; push_words(6, 11); tx_enable = 1;
    wait_strobes(10, 100, "t2");
    for (int i = 0; i < 6 && i < log_i0.size(); i++) check("t2 order", log_i0[i], 11 + i);
    for (int i = 6; i < 10 && i < log_i0.size(); i++) begin
      check("t2 zero data", log_i0[i], 0);
      check("t2 ucnt", log_u[i], i - 5);
    end
    check_spacing(0, 9, 2, "t2 spacing");
    tx_enable = 0; tick(8);

    // fill to full while disabled; 17th push dropped
    do_reset();
    mode_1r1t = 0; push_words(17, 1);
    check("t3 s_ready full", s_ready, 0);
    check("t3 level full", fifo_level, 16);
    tx_enable = 1;
    wait_strobes(20, 200, "t3");
    nz = 0;
    foreach (log_i0[i]) if (log_i0[i] != 0) nz++;
    check("t3 nonzero strobes", nz, 16);
    tx_enable = 0; tick(8);

    // drop enable at phase 2; queue retained
    do_reset();
    push_words(8, 21); tx_enable = 1;
    wait_strobes(1, 50, "t4");
    tx_enable = 0; tick(12);
    check("t4 strobes after drop", log_i0.size(), 1);
    check("t4 level kept", fifo_level, 7);
    check("t4 idle", streaming, 0);
    clear_log(); tx_enable = 1;
    wait_strobes(1, 50, "t4b");
    if (log_i0.size() > 0) check("t4 resume word", log_i0[0], 22);
    tx_enable = 0; tick(8);

    // mode change ignored until the next IDLE->PRIME
    do_reset();
    mode_1r1t = 0; push_words(12, 31); tx_enable = 1;
    wait_strobes(1, 50, "t5");
    mode_1r1t = 1;
    wait_strobes(4, 50, "t5b");
    check_spacing(0, 3, 4, "t5 held period");
    tx_enable = 0; tick(8);
    clear_log(); tx_enable = 1;
    wait_strobes(3, 50, "t5c");
    check_spacing(0, 2, 2, "t5 new period");
    tx_enable = 0; tick(8); mode_1r1t = 0;

    // reset mid-run with 5 words queued
    do_reset();
    push_words(8, 41); tx_enable = 1;
    wait_strobes(3, 50, "t6");
    check("t6 level before reset", fifo_level, 5);
    rst_n = 0; tick(1);
    check("t6 rst valid", dac_valid, 0);
    check("t6 rst data", {d_i0, d_q0, d_i1, d_q1}, 0);
    check("t6 rst level", fifo_level, 0);
    check("t6 rst streaming", streaming, 0);
    rst_n = 1; clear_log(); tick(20);
    check("t6 no strobes unprimed", log_i0.size(), 0);
    push_words(4, 51);
    wait_strobes(1, 50, "t6b");
    if (log_i0.size() > 0) check("t6 reprimed word", log_i0[0], 51);
    tx_enable = 0; tick(8);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 9) < 4);
      s_i0 = 12'($urandom); s_q0 = 12'($urandom); s_i1 = 12'($urandom); s_q1 = 12'($urandom);
      if ($urandom_range(0, 39) == 0) tx_enable = ~tx_enable;
      if ($urandom_range(0, 29) == 0) mode_1r1t = ~mode_1r1t;
      rst_n = ($urandom_range(0, 399) != 0);
      tick(1);
    end
    rst_n = 1; s_valid = 0; tx_enable = 0; tick(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
